// File: rtl/data_mem_responder_pkg.sv
// Shared types and widths for the data memory responder.
// State encoding, word width and wait-counter width.
package srm_mem_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Requester <-> responder memory bus.
// master: mem_req/mem_we/d_addr/dout out; slave: din/mem_ack/mem_err out.
interface data_mem_responder_if;
    import srm_mem_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [31:0]       d_addr;
    logic [WORD_W-1:0] dout;
    logic [WORD_W-1:0] din;
    logic              mem_ack;
    logic              mem_err;

    modport master (
        output mem_req, mem_we, d_addr, dout,
        input  din, mem_ack, mem_err
    );

    modport slave (
        input  mem_req, mem_we, d_addr, dout,
        output din, mem_ack, mem_err
    );

endinterface

// File: rtl/data_mem_responder_sram_1p.sv
// Single-port DEPTH x 32 memory: sync write, registered sync read.
// Ports: clk, rst_n (read register only), en, we, clr, addr, wdata, rdata.
module sram_1p
    import srm_mem_pkg::*;
#(
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic              clr,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Array contents are never reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register holds until the next read; clr returns zero for
    // reads that fall outside the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (clr) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory responder: accepts a request, waits WAIT_STATES, then acks.
// Ports: clk, rst_n, bus (slave: req/we/addr/dout in; din/ack/err out).
module data_mem_responder
    import srm_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam bit HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [CNT_W-1:0] CNT_INIT =
        HAS_WAIT ? CNT_W'(WAIT_STATES - 1) : '0;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              ack_q;
    logic              ack_d;
    logic              err_q;
    logic              err_d;

    logic              we_q;
    logic [29:0]       idx_q;
    logic [WORD_W-1:0] data_q;

    logic              accept;
    logic              go_ack;
    logic              acc_we;
    logic [29:0]       acc_idx;
    logic [WORD_W-1:0] acc_data;
    logic              acc_oor;

    logic              unused_addr;
    assign unused_addr = ^bus.d_addr[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        go_ack  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.mem_req) begin
                    accept = 1'b1;
                    if (HAS_WAIT) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = ACK;
                        go_ack  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ACK;
                    go_ack  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // With no wait states the accept edge is also the ACK-entry edge,
    // so the storage access must use the live request, not the latches.
    always_comb begin
        acc_we   = accept ? bus.mem_we       : we_q;
        acc_idx  = accept ? bus.d_addr[31:2] : idx_q;
        acc_data = accept ? bus.dout         : data_q;
    end

    if (AW < 30) begin : g_rng
        assign acc_oor = |acc_idx[29:AW];
    end else begin : g_full
        assign acc_oor = 1'b0;
    end

    always_comb begin
        ack_d = go_ack;
        err_d = go_ack & acc_oor;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            idx_q  <= '0;
            data_q <= '0;
        end else if (accept) begin
            we_q   <= bus.mem_we;
            idx_q  <= bus.d_addr[31:2];
            data_q <= bus.dout;
        end
    end

    sram_1p #(
        .DEPTH (DEPTH_WORDS)
    ) u_sram (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (go_ack & ~acc_oor),
        .we    (acc_we),
        .clr   (go_ack & acc_oor & ~acc_we),
        .addr  (acc_idx[AW-1:0]),
        .wdata (acc_data),
        .rdata (bus.din)
    );

    assign bus.mem_ack = ack_q;
    assign bus.mem_err = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder at WAIT_STATES 0, 1 and 2.
// Directed cases plus random traffic against a word-array model.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic        req  [3];
    logic        we   [3];
    logic [31:0] addr [3];
    logic [31:0] wd   [3];
    logic [31:0] din  [3];
    logic        ack  [3];
    logic        err  [3];

    int errors = 0;
    int checks = 0;

    bit [31:0] mdl  [3][DEPTH];
    bit [31:0] last [3];

    data_mem_responder_if bus0 ();
    data_mem_responder_if bus1 ();
    data_mem_responder_if bus2 ();

    assign bus0.mem_req = req[0];
    assign bus0.mem_we  = we[0];
    assign bus0.d_addr  = addr[0];
    assign bus0.dout    = wd[0];
    assign din[0] = bus0.din;
    assign ack[0] = bus0.mem_ack;
    assign err[0] = bus0.mem_err;

    assign bus1.mem_req = req[1];
    assign bus1.mem_we  = we[1];
    assign bus1.d_addr  = addr[1];
    assign bus1.dout    = wd[1];
    assign din[1] = bus1.din;
    assign ack[1] = bus1.mem_ack;
    assign err[1] = bus1.mem_err;

    assign bus2.mem_req = req[2];
    assign bus2.mem_we  = we[2];
    assign bus2.d_addr  = addr[2];
    assign bus2.dout    = wd[2];
    assign din[2] = bus2.din;
    assign ack[2] = bus2.mem_ack;
    assign err[2] = bus2.mem_err;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));
    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction on instance k; returns what the requester saw.
    task automatic xact(input int k, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input bit scr,
                        output logic [31:0] rd, output logic er,
                        output int lat);
        @(negedge clk);
        req[k]  = 1'b1;
        we[k]   = w;
        addr[k] = a;
        wd[k]   = d;
        @(posedge clk);
        #1;
        req[k] = 1'b0;
        if (scr) begin
            addr[k] = a + 32'd4;
            wd[k]   = 32'd0;
            we[k]   = ~w;
        end
        lat = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            lat++;
            if (ack[k]) break;
        end
        if (ack[k] !== 1'b1) chk("ack_timeout", {31'd0, ack[k]}, 32'd1);
        rd = din[k];
        er = err[k];
        @(negedge clk);
        chk("ack_single", {31'd0, ack[k]}, 32'd0);
    endtask

    // Transaction plus comparison against the model.
    // Instance k has WAIT_STATES = k, so latency is k+1.
    task automatic op(input int k, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input bit scr);
        logic [31:0] rd;
        logic        er;
        int          lat;
        int unsigned idx;
        bit          oor;
        idx = a >> 2;
        oor = (idx >= DEPTH);
        xact(k, w, a, d, scr, rd, er, lat);
        chk("latency", lat, k + 1);
        chk("mem_err", {31'd0, er}, {31'd0, oor});
        if (w) begin
            if (!oor) mdl[k][idx] = d;
            chk("din_hold_on_write", rd, last[k]);
        end else begin
            last[k] = oor ? 32'd0 : mdl[k][idx];
            chk("read_data", rd, last[k]);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        for (int k = 0; k < 3; k++) begin
            req[k] = 0; we[k] = 0; addr[k] = 0; wd[k] = 0;
            last[k] = 0;
        end

        // Reset values
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_din", din[k], 32'd0);
            chk("rst_ack", {31'd0, ack[k]}, 32'd0);
            chk("rst_err", {31'd0, err[k]}, 32'd0);
        end
        rst_n = 1'b1;

        // W=1 write then read, 2-cycle latency
        op(1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        op(1, 1'b0, 32'h10, 32'h0, 1'b0);

        // W=0, byte offset ignored, big-endian byte 0
        op(0, 1'b1, 32'h10, 32'h11223344, 1'b0);
        xact(0, 1'b0, 32'h13, 32'h0, 1'b0, rd, er, lat);
        chk("w0_latency", lat, 1);
        chk("w0_din", rd, 32'h11223344);
        chk("w0_byte0", {24'd0, rd[31:24]}, 32'h11);
        chk("w0_err", {31'd0, er}, 32'd0);
        last[0] = 32'h11223344;

        // Fill words 0..63 so every later read has a known value
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 64; i++) begin
                op(k, 1'b1, i * 4, $urandom, 1'b0);
            end
        end

        // Out-of-range write/read; word 0 untouched
        op(1, 1'b1, 32'h1000, 32'hFFFFFFFF, 1'b0);
        op(1, 1'b0, 32'h1000, 32'h0, 1'b0);
        op(1, 1'b0, 32'h0, 32'h0, 1'b0);

        // Request changes after accept have no effect
        op(1, 1'b1, 32'h20, 32'hAAAA5555, 1'b1);
        op(1, 1'b0, 32'h20, 32'h0, 1'b0);
        op(1, 1'b0, 32'h24, 32'h0, 1'b0);

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < 3; k++) begin
                logic [31:0] a;
                if ($urandom_range(0, 7) == 0)
                    a = ($urandom_range(DEPTH, 1 << 28) << 2);
                else
                    a = ($urandom_range(0, 63) << 2);
                a[1:0] = 2'($urandom_range(0, 3));
                op(k, 1'($urandom_range(0, 1)), a, $urandom, 1'b0);
            end
        end

        // W=2 with mem_req held high: an ack every W+2 cycles
        @(negedge clk);
        req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h0;
        for (int i = 1; i <= 20; i++) begin
            bit exp_ack;
            @(negedge clk);
            exp_ack = (i >= 3) && ((i - 3) % 4 == 0);
            chk("held_req_ack", {31'd0, ack[2]}, {31'd0, exp_ack});
            if (exp_ack) chk("held_req_din", din[2], mdl[2][0]);
        end
        req[2] = 1'b0;
        last[2] = mdl[2][0];
        repeat (4) @(negedge clk);

        // Reset during WAIT of a write aborts it
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1;
        addr[1] = 32'h30; wd[1] = 32'h12345678;
        @(posedge clk);
        #1;
        req[1] = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_ack", {31'd0, ack[1]}, 32'd0);
            chk("abort_err", {31'd0, err[1]}, 32'd0);
            chk("abort_din", din[1], 32'd0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) last[k] = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_late_ack", {31'd0, ack[1]}, 32'd0);
        end
        op(1, 1'b0, 32'h30, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored (power of two, at least 4).
REQ-002 SHALL have parameter WAIT_STATES, default 1, number of idle cycles inserted between accept and acknowledge (range 0..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port mem_req, input, 1, requester asks for one memory transaction.
REQ-006 SHALL have port mem_we, input, 1, 1 = write, 0 = read; sampled at accept.
REQ-007 SHALL have port d_addr, input, 32, byte address; sampled at accept.
REQ-008 SHALL have port dout, input, 32, write data, already byte/halfword-merged by the requester; sampled at accept.
REQ-009 SHALL have port din, output, 32, read data returned to the requester.
REQ-010 SHALL have port mem_ack, output, 1, one-cycle transaction-complete strobe.
REQ-011 SHALL have port mem_err, output, 1, out-of-range flag, valid only while mem_ack=1.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, ACK.
REQ-013 IDLE with mem_req=1 SHALL accept: latch mem_we, word index d_addr[31:2], and dout; then go to WAIT if WAIT_STATES>0, else to ACK.
REQ-014 WAIT SHALL load a counter with WAIT_STATES-1 on entry, decrement it each cycle, and go to ACK at the edge where the counter is 0; mem_req SHALL be ignored in WAIT.
REQ-015 The storage access SHALL occur on the edge that enters ACK: a write stores the latched data; a read registers the stored word onto din.
REQ-016 ACK SHALL drive mem_ack=1 for exactly one cycle, then go to IDLE unconditionally; mem_req SHALL be ignored in ACK.
REQ-017 Latency from the accept edge to the mem_ack=1 cycle SHALL be WAIT_STATES+1 cycles; back-to-back accepts SHALL be spaced at least WAIT_STATES+2 cycles apart.
REQ-018 d_addr[1:0] SHALL be ignored; data is big-endian, with byte 0 in din[31:24].
REQ-019 If d_addr[31:2] >= DEPTH_WORDS: a write SHALL be discarded, a read SHALL return din=0, and mem_err=1 SHALL be asserted in ACK.
REQ-020 din SHALL hold its value until the next read completes; writes SHALL not change din.
REQ-021 Changes to mem_we, d_addr, or dout after accept SHALL have no effect on the accepted transaction.
REQ-022 Read-after-write to the same word SHALL return the newly written data when the read is accepted after the write's ACK cycle.
REQ-023 mem_ack and mem_err SHALL be registered outputs with no combinational path from any input.

Reset
REQ-024 On rst_n=0 the state SHALL be IDLE, with mem_ack=0, mem_err=0, din=0, the counter at 0, and all latched request registers at 0.
REQ-025 Reset asserted in WAIT or ACK SHALL abort the transaction; a pending write SHALL not be committed, and no mem_ack SHALL follow.
REQ-026 Storage contents SHALL not be reset.
REQ-027 After rst_n deasserts, the first edge with mem_req=1 SHALL be accepted.

Structure
REQ-028 Package srm_mem_pkg SHALL hold the state enum (IDLE, WAIT, ACK), the word width constant (32), and the wait-counter width (4).
REQ-029 Storage SHALL be a sub-module sram_1p: a single-port memory of DEPTH_WORDS x 32 bits with synchronous write and synchronous registered read, one access per cycle.
REQ-030 data_mem_responder SHALL contain only the FSM, the counter, the request latches, and the range check.

Verification
REQ-031 With WAIT_STATES=1: write 0xDEADBEEF to 0x10, then read 0x10; each mem_ack occurs 2 cycles after its accept, and the read returns din=0xDEADBEEF with mem_err=0.
REQ-032 With WAIT_STATES=0: issue a read of 0x13 after writing 0x11223344 to 0x10; mem_ack occurs 1 cycle after accept, din=0x11223344, and din[31:24]=0x11.
REQ-033 With DEPTH_WORDS=1024: write 0xFFFFFFFF to 0x1000, then read 0x1000; both return mem_err=1, the read returns din=0, and a read of 0x0 still returns its prior value.
REQ-034 Hold mem_req=1 continuously with WAIT_STATES=2; accepts occur every 4 cycles, and mem_ack pulses are single-cycle and non-overlapping.
REQ-035 Write 0xAAAA5555 to 0x20; change d_addr to 0x24 and dout to 0 during WAIT; 0x20 holds 0xAAAA5555 and 0x24 is unchanged.
REQ-036 Pull rst_n low during WAIT of a write of 0x12345678 to 0x30; no mem_ack occurs, all outputs read 0, and a later read of 0x30 returns the old contents.
